flit_proc_buf: RTL and testbench
================================

FLIT_PROC_BUF -- requirements
Module: flit_proc_buf

Interface
REQ-001 Parameter FLIT_W, default 14: flit width in bits; bit FLIT_W-1 is the processed flag, bits [FLIT_W-2:0] are the payload.
REQ-002 Parameter DEPTH, default 4: input FIFO depth in flits; power of two, minimum 2.
REQ-003 Parameter CNT_W, default 16: width of each statistics counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  2  transform select: 0 pass, 1 flip-LSB, 2 increment, 3 drop.
REQ-007 in_valid  input  1  upstream flit valid.
REQ-008 in_data  input  FLIT_W  upstream flit.
REQ-009 in_ready  output  1  block can accept a flit.
REQ-010 out_valid  output  1  processed flit valid.
REQ-011 out_data  output  FLIT_W  processed flit.
REQ-012 out_ready  input  1  downstream accepts a flit.
REQ-013 occupancy  output  $clog2(DEPTH)+1  flits currently in the FIFO.
REQ-014 proc_cnt  output  CNT_W  flits delivered downstream.
REQ-015 drop_cnt  output  CNT_W  flits discarded in mode 3.

Function
REQ-016 The block shall accept a flit on each rising edge where in_valid and in_ready are both high, and write it to the FIFO tail.
REQ-017 in_ready shall equal (occupancy != DEPTH), registered state only, with no combinational path from out_ready or in_valid.
REQ-018 The output stage shall be a single register; the FIFO head shall pop when the FIFO is non-empty and either out_valid is low or out_valid and out_ready are both high.
REQ-019 mode shall be sampled on the pop edge and applied to the popped flit; later mode changes shall not affect flits already in the output register.
REQ-020 Mode 0 shall load out_data with in_data unchanged, including bit FLIT_W-1.
REQ-021 Mode 1 shall load out_data with {1, d[FLIT_W-2:1], ~d[0]}.
REQ-022 Mode 2 shall load out_data with {1, (d[FLIT_W-2:0]+1) mod 2^(FLIT_W-1)}; the payload wraps and no carry reaches the flag bit.
REQ-023 Mode 3 shall consume the popped flit without loading the output register; out_valid shall be unaffected and drop_cnt shall increment.
REQ-024 out_valid and out_data shall hold stable while out_valid is high and out_ready is low.
REQ-025 Minimum latency: a flit accepted at edge k into an empty FIFO, with the output register free, shall appear with out_valid high after edge k+1.
REQ-026 Throughput shall be one flit per cycle when in_valid and out_ready are held high.
REQ-027 A simultaneous push and pop shall leave occupancy unchanged; full and empty shall be derived from an occupancy counter, not from pointer equality alone.
REQ-028 FIFO read and write pointers shall wrap modulo DEPTH.
REQ-029 proc_cnt shall increment on each edge where out_valid and out_ready are high.
REQ-030 proc_cnt and drop_cnt shall saturate at 2^CNT_W-1.

Reset
REQ-031 While rst is high, on a rising edge the block shall clear the FIFO pointers and occupancy, and set out_valid, out_data, proc_cnt and drop_cnt to 0.
REQ-032 in_ready shall be 1 on the first edge after rst deasserts.
REQ-033 Reset asserted mid-operation shall discard all buffered and in-flight flits; no flit accepted before reset shall appear at the output after reset.

Structure
REQ-034 A shared package flit_pkg shall hold the mode enumeration (MODE_PASS, MODE_FLIP, MODE_INC, MODE_DROP) and the flit transform function.
REQ-035 The FIFO shall be a separate sub-module, flit_fifo, parametrised by FLIT_W and DEPTH, exposing push, pop, full, empty and count.
REQ-036 All statistics counters and the output register shall reside in flit_proc_buf.

Verification (FLIT_W=14, DEPTH=4, CNT_W=16)
REQ-037 Mode 1, push 0x0005, out_ready=1 -> out_data=0x2004 one edge after acceptance; proc_cnt=1.
REQ-038 Mode 2, push 0x1FFF -> out_data=0x2000 (payload wrap); mode 0, push 0x1234 -> out_data=0x1234.
REQ-039 out_ready=0, push 6 flits -> 5 accepted (4 in FIFO, 1 in output register); in_ready=0 and occupancy=4; out_data stable. Then release out_ready -> 5 flits delivered in order, one per cycle.
REQ-040 Mode 3, push 3 flits -> out_valid stays 0; drop_cnt=3; proc_cnt unchanged.
REQ-041 Continuous in_valid=1 and out_ready=1 for 20 cycles in mode 1 -> 1 flit per cycle, in order, occupancy never exceeds 1.
REQ-042 Assert rst with 3 flits buffered and out_valid=1 -> after reset: out_valid=0, occupancy=0, counters=0, in_ready=1; no stale flit is ever emitted.

Source files
------------

// File: rtl/flit_pkg.sv
// flit_pkg
//   Shared definitions for the flit processing buffer: the transform mode
//   enumeration and the flit transform function used on the FIFO pop path.
//   Flits are at most FLIT_W_MAX bits wide. The transform works on a
//   zero-extended flit, and the caller truncates the result back to its own
//   width. This lets every instance share one function regardless of FLIT_W.
package flit_pkg;

  localparam int FLIT_W_MAX = 64;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_FLIP = 2'd1,
    MODE_INC  = 2'd2,
    MODE_DROP = 2'd3
  } mode_t;

  // The processed flag is bit w-1, and the payload is the bits below it.
  // In increment mode the payload is masked after the add. This keeps the
  // carry out of the payload from reaching the flag bit.
  function automatic logic [FLIT_W_MAX-1:0] flit_transform(
    input mode_t                 m,
    input logic [FLIT_W_MAX-1:0] d,
    input int                    w
  );
    logic [FLIT_W_MAX-1:0] flag;
    logic [FLIT_W_MAX-1:0] mask;
    logic [FLIT_W_MAX-1:0] r;
    flag = FLIT_W_MAX'(1) << (w - 1);
    mask = flag - FLIT_W_MAX'(1);
    case (m)
      MODE_FLIP: r = flag | ((d & mask) ^ FLIT_W_MAX'(1));
      MODE_INC:  r = flag | (((d & mask) + FLIT_W_MAX'(1)) & mask);
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo
//   Circular-buffer FIFO for flits. The full and empty flags come from an
//   occupancy counter. Comparing the pointers alone cannot tell a full buffer
//   from an empty one. The read and write pointers wrap modulo DEPTH, and
//   DEPTH must be a power of two.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_data at the tail (ignored when full)
//   i_data     flit to write
//   i_pop      advance the head (ignored when empty)
//   o_data     flit at the head (valid when not empty)
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    flits currently stored
module flit_fifo #(
  parameter int FLIT_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [FLIT_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [FLIT_W-1:0]          o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage has no reset, because occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // A push and a pop in the same cycle leave the count unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/flit_proc_buf.sv
// flit_proc_buf
//   Input FIFO followed by a single output register. Each flit popped from
//   the FIFO is transformed according to mode, which is sampled on the pop
//   edge, and loaded into the output register. In drop mode the popped flit
//   is discarded. The block also keeps saturating counts of delivered and
//   dropped flits.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode                0 pass, 1 flip LSB, 2 increment payload, 3 drop
//   in_valid/in_data    upstream flit; in_ready = FIFO not full
//   out_valid/out_data  processed flit; out_ready from downstream
//   occupancy           flits held in the FIFO
//   proc_cnt, drop_cnt  delivered / dropped flit counts
module flit_proc_buf
  import flit_pkg::*;
#(
  parameter int FLIT_W = 14,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  input  logic [FLIT_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [FLIT_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       proc_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic              w_full;
  logic              w_empty;
  logic [FLIT_W-1:0] w_head;
  logic [FLIT_W-1:0] w_xform;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  mode_t             w_mode;

  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_proc_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  // in_ready depends only on the FIFO count register. It has no path from in_valid or out_ready.
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;
  // The head pops whenever the output register is free or is being emptied this cycle.
  assign w_pop    = ~w_empty & (~r_out_valid | out_ready);
  assign w_mode   = mode_t'(mode);
  assign w_drop   = (w_mode == MODE_DROP);
  assign w_xform  = FLIT_W'(flit_transform(w_mode, FLIT_W_MAX'(w_head), FLIT_W));

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  // Output register and counters. A new load overrides the clear from a handshake.
  // A drop pop loads nothing, so a handshake in the same cycle still empties the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_proc_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        if (r_proc_cnt != '1) r_proc_cnt <= r_proc_cnt + 1'b1;
      end
      if (w_pop && !w_drop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_xform;
      end
      if (w_pop && w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign proc_cnt  = r_proc_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_flit_proc_buf.sv
// tb_flit_proc_buf
//   Self-checking bench for flit_proc_buf (FLIT_W=14, DEPTH=4, CNT_W=16).
//   A negedge monitor acts as a scoreboard. It pushes the expected output for
//   each accepted flit and pops and compares on every output handshake.
//   Single-flit vectors come from a table. The backpressure, drop, streaming
//   and mid-operation reset cases are hand-written sequences.
module tb_flit_proc_buf;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [13:0] out_data;
  logic        out_ready;
  logic [2:0]  occupancy;
  logic [15:0] proc_cnt;
  logic [15:0] drop_cnt;

  int testsRun;
  int testsFailed;
  int nDelivered;
  logic [13:0] expQ[$];

  flit_proc_buf #(
    .FLIT_W (14),
    .DEPTH  (4),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .proc_cnt  (proc_cnt),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench model of the transform, written directly for a 14-bit flit.
  function automatic logic [13:0] model(input logic [1:0] m, input logic [13:0] d);
    logic [12:0] p;
    case (m)
      2'd1:    return {1'b1, d[12:1], ~d[0]};
      2'd2:    begin p = d[12:0] + 13'd1; return {1'b1, p}; end
      default: return d;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic v, input logic [13:0] d, input logic rdy);
    mode      = m;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  // Scoreboard: record accepted flits, compare delivered ones in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready && mode != 2'd3) expQ.push_back(model(mode, in_data));
      if (out_valid && out_ready) begin
        nDelivered++;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected output: got 0x%0h, expected no flit", out_data);
        end else begin
          checkOutput("scoreboard order/data", 32'(out_data), 32'(expQ.pop_front()));
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  m;
    logic [13:0] d;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int validCycles;
    int maxOcc;
    logic acc;

    vecs[0] = '{2'd1, 14'h0005, 14'h2004};
    vecs[1] = '{2'd2, 14'h1FFF, 14'h2000};
    vecs[2] = '{2'd0, 14'h1234, 14'h1234};
    vecs[3] = '{2'd1, 14'h3FFF, 14'h3FFE};
    vecs[4] = '{2'd2, 14'h2005, 14'h2006};
    vecs[5] = '{2'd0, 14'h3ABC, 14'h3ABC};

    testsRun = 0;
    testsFailed = 0;
    nDelivered = 0;

    // Reset state
    rst = 1'b1;
    applyStimulus(2'd0, 1'b0, 14'h0, 1'b0);
    tick();
    tick();
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset occupancy", 32'(occupancy), 0);
    checkOutput("reset proc_cnt", 32'(proc_cnt), 0);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    tick();
    checkOutput("in_ready after reset", 32'(in_ready), 1);

    // Single-flit vectors: the flit is visible one edge after acceptance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].m, 1'b1, vecs[i].d, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput("vector out_valid", 32'(out_valid), 1);
      checkOutput("vector out_data", 32'(out_data), 32'(vecs[i].exp));
      tick();
      checkOutput("vector proc_cnt", 32'(proc_cnt), 32'(i + 1));
    end

    // Backpressure: 6 offered flits, 5 accepted
    n = 0;
    applyStimulus(2'd0, 1'b1, 14'h0100, 1'b0);
    for (int c = 0; c < 8; c++) begin
      in_valid = (n < 6);
      in_data  = 14'(14'h0100 + n);
      acc = in_valid && in_ready;
      tick();
      if (acc) n++;
    end
    in_valid = 1'b0;
    checkOutput("backpressure accepted", 32'(n), 5);
    checkOutput("backpressure in_ready", 32'(in_ready), 0);
    checkOutput("backpressure occupancy", 32'(occupancy), 4);
    for (int c = 0; c < 2; c++) begin
      checkOutput("backpressure out_valid held", 32'(out_valid), 1);
      checkOutput("backpressure out_data held", 32'(out_data), 32'h0100);
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checkOutput("drain out_valid", 32'(out_valid), 1);
      checkOutput("drain out_data", 32'(out_data), 32'(14'h0100 + j));
      tick();
    end
    checkOutput("drain done out_valid", 32'(out_valid), 0);
    checkOutput("drain done occupancy", 32'(occupancy), 0);
    checkOutput("drain proc_cnt", 32'(proc_cnt), 11);

    // Drop mode
    validCycles = 0;
    applyStimulus(2'd3, 1'b1, 14'h0AAA, 1'b1);
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3);
      in_data  = 14'(14'h0AAA + c);
      tick();
      if (out_valid) validCycles++;
    end
    checkOutput("drop out_valid cycles", 32'(validCycles), 0);
    checkOutput("drop drop_cnt", 32'(drop_cnt), 3);
    checkOutput("drop proc_cnt", 32'(proc_cnt), 11);

    // Streaming: one flit per cycle in flip mode
    nDelivered = 0;
    validCycles = 0;
    maxOcc = 0;
    applyStimulus(2'd1, 1'b1, 14'h0200, 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_data = 14'(14'h0200 + i);
      tick();
      if (out_valid) validCycles++;
      if (int'(occupancy) > maxOcc) maxOcc = int'(occupancy);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checkOutput("stream valid cycles", 32'(validCycles), 19);
    checkOutput("stream max occupancy", 32'(maxOcc), 1);
    checkOutput("stream delivered", 32'(nDelivered), 20);
    checkOutput("stream proc_cnt", 32'(proc_cnt), 31);
    checkOutput("stream queue drained", 32'(expQ.size()), 0);

    // Reset mid-operation with flits buffered
    applyStimulus(2'd0, 1'b1, 14'h0300, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_data = 14'(14'h0300 + i);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("pre-reset out_valid", 32'(out_valid), 1);
    checkOutput("pre-reset occupancy", 32'(occupancy), 3);
    rst = 1'b1;
    tick();
    expQ.delete();
    checkOutput("mid reset out_valid", 32'(out_valid), 0);
    checkOutput("mid reset occupancy", 32'(occupancy), 0);
    checkOutput("mid reset proc_cnt", 32'(proc_cnt), 0);
    checkOutput("mid reset drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    tick();
    checkOutput("post reset in_ready", 32'(in_ready), 1);
    nDelivered = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    checkOutput("post reset no stale out_valid", 32'(out_valid), 0);
    checkOutput("post reset delivered", 32'(nDelivered), 0);
    checkOutput("post reset proc_cnt", 32'(proc_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
